// File: rtl/tiger_muldiv_ctrl.sv
// tiger_muldiv_ctrl: HI/LO sequencer for pipelined multiply, restoring divide and MTHI/MTLO
module tiger_muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, r_q, r_d, hi_q, hi_d, lo_q, lo_d;
  logic        sg_q, sg_d, nq_q, nq_d, nr_q, nr_d, busy_q, busy_d;
  logic        accept;
  logic [32:0] rsh, diff;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b;
  // next-state: accept, multiply countdown, one restoring divide step per cycle, sign fix, flush abort
  always_comb begin
    accept = req_valid & ~busy_q & ~flush;
    rsh = {r_q, a_q[31]};
    diff = rsh - {1'b0, b_q};
    prod = {{32{sg_q & a_q[31]}}, a_q} * {{32{sg_q & b_q[31]}}, b_q};
    abs_a = (~req_op[0] & rs_val[31]) ? -rs_val : rs_val;
    abs_b = (~req_op[0] & rt_val[31]) ? -rt_val : rt_val;
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    hi_d = hi_q;
    lo_d = lo_q;
    sg_d = sg_q;
    nq_d = nq_q;
    nr_d = nr_q;
    case (state_q)
      IDLE: if (accept) begin
        if (req_op[2:1] == 2'b00) begin
          state_d = MUL;
          a_d = rs_val;
          b_d = rt_val;
          sg_d = ~req_op[0];
          cnt_d = 5'd0;
        end else if (req_op[2:1] == 2'b01) begin
          state_d = DIV;
          a_d = abs_a;
          b_d = abs_b;
          r_d = 32'd0;
          cnt_d = 5'd0;
          nq_d = ~req_op[0] & (rs_val[31] ^ rt_val[31]);
          nr_d = ~req_op[0] & rs_val[31];
        end else if (req_op == 3'b100) begin
          hi_d = rs_val;
        end else if (req_op == 3'b101) begin
          lo_d = rs_val;
        end
      end
      MUL: if (cnt_q == 5'(MUL_LAT - 1)) begin
        {hi_d, lo_d} = prod;
        state_d = IDLE;
        cnt_d = 5'd0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
      DIV: begin
        r_d = diff[32] ? rsh[31:0] : diff[31:0];
        a_d = {a_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? FIX : DIV;
      end
      FIX: begin
        lo_d = nq_q ? -a_q : a_q;
        hi_d = nr_q ? -r_q : r_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      hi_d = hi_q;
      lo_d = lo_q;
      cnt_d = 5'd0;
    end
    busy_d = state_d != IDLE;
  end
  // state and HI/LO registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      r_q <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      sg_q <= 1'b0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      sg_q <= sg_d;
      nq_q <= nq_d;
      nr_q <= nr_d;
      busy_q <= busy_d;
    end
  end
  assign stall = busy_q & (req_valid | mf_req);
  assign busy = busy_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
